somador_pipe: RTL and testbench



---
 rtl/somador_pipe_if.sv | 26 ++
 rtl/somador_pipe.sv | 116 +++++++++++
 tb/tb_somador_pipe.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/somador_pipe_if.sv
// Operand/result handshake bundle for somador_pipe.
// master = producer/consumer side, slave = the adder pipeline.
interface somador_pipe_if #(
   parameter int WIDTH = 24
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] saida;
   logic             Cout;

   modport master (
      output in_valid, A, B, Cin, sub, out_ready,
      input  in_ready, out_valid, saida, Cout
   );

   modport slave (
      input  in_valid, A, B, Cin, sub, out_ready,
      output in_ready, out_valid, saida, Cout
   );
endinterface

// File: rtl/somador_pipe.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit carry-chained segment per stage,
// whole pipeline advances or stalls together, optional unsigned saturation at the exit.
module somador_pipe #(
   parameter int WIDTH  = 24,
   parameter int STAGES = 3,
   parameter bit SAT    = 1'b0
) (
   input logic           clk,
   input logic           rst_n,
   somador_pipe_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;

   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] a_d   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] b_d   [STAGES];
   logic [WIDTH-1:0] res_q [STAGES];
   logic [WIDTH-1:0] res_d [STAGES];
   logic             carry_q [STAGES];
   logic             carry_d [STAGES];
   logic             sub_q   [STAGES];
   logic             sub_d   [STAGES];
   logic             valid_q [STAGES];
   logic             valid_d [STAGES];

   logic [WIDTH-1:0] in_a   [STAGES];
   logic [WIDTH-1:0] in_b   [STAGES];
   logic [WIDTH-1:0] in_res [STAGES];
   logic             in_c   [STAGES];
   logic             in_sub [STAGES];
   logic             in_v   [STAGES];
   logic [CHUNK:0]   sum;
   logic             adv;

   always_comb begin
      adv = !valid_q[STAGES-1] || bus.out_ready;

      // B and Cin are inverted once at capture; later stages only see the effective operand.
      in_a[0]   = bus.A;
      in_b[0]   = bus.sub ? ~bus.B : bus.B;
      in_c[0]   = bus.sub ? ~bus.Cin : bus.Cin;
      in_sub[0] = bus.sub;
      in_v[0]   = bus.in_valid;
      in_res[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         in_a[k]   = a_q[k-1];
         in_b[k]   = b_q[k-1];
         in_c[k]   = carry_q[k-1];
         in_sub[k] = sub_q[k-1];
         in_v[k]   = valid_q[k-1];
         in_res[k] = res_q[k-1];
      end

      sum = '0;
      for (int k = 0; k < STAGES; k++) begin
         sum = {1'b0, in_a[k][k*CHUNK +: CHUNK]}
             + {1'b0, in_b[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, in_c[k]};
         a_d[k]     = in_a[k];
         b_d[k]     = in_b[k];
         sub_d[k]   = in_sub[k];
         valid_d[k] = in_v[k];
         carry_d[k] = sum[CHUNK];
         res_d[k]   = in_res[k];
         res_d[k][k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
      end

      // Saturation alters only the result; Cout leaves unmodified.
      if (SAT) begin
         if (!sub_d[STAGES-1] && carry_d[STAGES-1]) begin
            res_d[STAGES-1] = '1;
         end else if (sub_d[STAGES-1] && !carry_d[STAGES-1]) begin
            res_d[STAGES-1] = '0;
         end
      end

      if (!adv) begin
         for (int k = 0; k < STAGES; k++) begin
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
            res_d[k]   = res_q[k];
            carry_d[k] = carry_q[k];
            sub_d[k]   = sub_q[k];
            valid_d[k] = valid_q[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            res_q[k]   <= '0;
            carry_q[k] <= 1'b0;
            sub_q[k]   <= 1'b0;
            valid_q[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            res_q[k]   <= res_d[k];
            carry_q[k] <= carry_d[k];
            sub_q[k]   <= sub_d[k];
            valid_q[k] <= valid_d[k];
         end
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = valid_q[STAGES-1];
   assign bus.saida     = res_q[STAGES-1];
   assign bus.Cout      = carry_q[STAGES-1];
endmodule

// File: tb/tb_somador_pipe.sv
// Bench for somador_pipe: five parameterisations share clock/reset, each with an
// in-order scoreboard fed from an arithmetic reference model.
module tb_somador_pipe;
   localparam int N = 5;

   logic clk;
   logic rst_n;

   logic        iv_d   [N];
   logic        cin_d  [N];
   logic        sub_d  [N];
   logic        ordy_d [N];
   logic [63:0] a_d    [N];
   logic [63:0] b_d    [N];
   logic [64:0] exp_d  [N];

   logic        ov_o [N];
   logic        ir_o [N];
   logic        co_o [N];
   logic [63:0] sa_o [N];

   int wid [N];
   int stg [N];
   bit sat [N];

   logic [64:0] sb    [N][256];
   int          acc_e [N][256];
   int          wr_p  [N];
   int          rd_p  [N];
   bit          acc   [N];
   bit          stall_prev [N];
   logic [64:0] held  [N];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int edge_cnt = 0;
   bit chk_lat = 1'b0;

   somador_pipe_if #(.WIDTH(24)) if0 ();
   somador_pipe_if #(.WIDTH(24)) if1 ();
   somador_pipe_if #(.WIDTH(8))  if2 ();
   somador_pipe_if #(.WIDTH(32)) if3 ();
   somador_pipe_if #(.WIDTH(24)) if4 ();

   somador_pipe #(.WIDTH(24), .STAGES(3), .SAT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   somador_pipe #(.WIDTH(24), .STAGES(3), .SAT(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   somador_pipe #(.WIDTH(8),  .STAGES(1), .SAT(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   somador_pipe #(.WIDTH(32), .STAGES(4), .SAT(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
   somador_pipe #(.WIDTH(24), .STAGES(8), .SAT(1'b0)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

`define HOOK(I, IFN, W) \
   assign IFN.in_valid  = iv_d[I]; \
   assign IFN.A         = a_d[I][W-1:0]; \
   assign IFN.B         = b_d[I][W-1:0]; \
   assign IFN.Cin       = cin_d[I]; \
   assign IFN.sub       = sub_d[I]; \
   assign IFN.out_ready = ordy_d[I]; \
   assign ov_o[I]       = IFN.out_valid; \
   assign ir_o[I]       = IFN.in_ready; \
   assign co_o[I]       = IFN.Cout; \
   assign sa_o[I]       = 64'(IFN.saida);

   `HOOK(0, if0, 24)
   `HOOK(1, if1, 24)
   `HOOK(2, if2, 8)
   `HOOK(3, if3, 32)
   `HOOK(4, if4, 24)

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [23:0] d_a   [10] = '{24'd100, 24'd100, 24'd150, 24'd250, 24'd250,
                               24'h00FFFF, 24'hFFFFFF, 24'd200, 24'd100, 24'd5};
   logic [23:0] d_b   [10] = '{24'd200, 24'd200, 24'd200, 24'd200, 24'd200,
                               24'd1, 24'd1, 24'd100, 24'd200, 24'd5};
   logic        d_cin [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic        d_sub [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
   // {Cout, saida} without and with saturation
   logic [24:0] d_e0  [10] = '{{1'b0, 24'd300}, {1'b0, 24'd301}, {1'b0, 24'd351}, {1'b0, 24'd451},
                               {1'b0, 24'd450}, {1'b0, 24'h010000}, {1'b1, 24'h000000},
                               {1'b1, 24'd100}, {1'b0, 24'hFFFF9C}, {1'b0, 24'hFFFFFF}};
   logic [24:0] d_e1  [10] = '{{1'b0, 24'd300}, {1'b0, 24'd301}, {1'b0, 24'd351}, {1'b0, 24'd451},
                               {1'b0, 24'd450}, {1'b0, 24'h010000}, {1'b1, 24'hFFFFFF},
                               {1'b1, 24'd100}, {1'b0, 24'h000000}, {1'b0, 24'h000000}};

   function automatic logic [64:0] model(int w, bit s, logic [63:0] a, logic [63:0] b,
                                         logic cin, logic sb_op);
      logic [63:0] m;
      logic [64:0] r;
      logic        co;
      logic [63:0] res;
      m = (64'd1 << w) - 64'd1;
      if (!sb_op) begin
         r   = {1'b0, a} + {1'b0, b} + 65'(cin);
         co  = r[w];
         res = r[63:0] & m;
         if (s && co) res = m;
      end else begin
         co  = (a >= b + 64'(cin));
         res = (a - b - 64'(cin)) & m;
         if (s && !co) res = '0;
      end
      return {co, res};
   endfunction

   task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a falling edge with inputs already driven; books the coming edge.
   task automatic cycle();
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("in_ready[%0d]", i), 65'(ir_o[i]), 65'(!ov_o[i] || ordy_d[i]));
         if (stall_prev[i])
            chk($sformatf("hold[%0d]", i), {co_o[i], sa_o[i]}, held[i]);
         if (wr_p[i] == rd_p[i])
            chk($sformatf("no_spurious[%0d]", i), 65'(ov_o[i]), 65'(0));
         if (ov_o[i] && ordy_d[i] && wr_p[i] != rd_p[i]) begin
            chk($sformatf("result[%0d]#%0d", i, rd_p[i]), {co_o[i], sa_o[i]}, sb[i][rd_p[i] % 256]);
            if (chk_lat)
               chk($sformatf("latency[%0d]", i), 65'(edge_cnt + 1 - acc_e[i][rd_p[i] % 256]), 65'(stg[i]));
            rd_p[i]++;
         end
         stall_prev[i] = ov_o[i] && !ordy_d[i];
         held[i]       = {co_o[i], sa_o[i]};
         acc[i]        = iv_d[i] && ir_o[i];
         if (acc[i]) begin
            sb[i][wr_p[i] % 256]    = exp_d[i];
            acc_e[i][wr_p[i] % 256] = edge_cnt + 1;
            wr_p[i]++;
         end
      end
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
   endtask

   task automatic drain(input int limit);
      bit busy;
      for (int i = 0; i < N; i++) begin
         iv_d[i]   = 1'b0;
         ordy_d[i] = 1'b1;
      end
      for (int t = 0; t < limit; t++) begin
         busy = 1'b0;
         for (int i = 0; i < N; i++) if (wr_p[i] != rd_p[i]) busy = 1'b1;
         if (!busy) break;
         cycle();
      end
      for (int i = 0; i < N; i++)
         chk($sformatf("drained[%0d]", i), 65'(rd_p[i]), 65'(wr_p[i]));
   endtask

   task automatic rand_op(input int i);
      logic [63:0] m;
      m = (64'd1 << wid[i]) - 64'd1;
      a_d[i]   = {$urandom, $urandom} & m;
      b_d[i]   = {$urandom, $urandom} & m;
      if ($urandom_range(0, 7) == 0) a_d[i] = m;
      if ($urandom_range(0, 7) == 0) b_d[i] = a_d[i];
      cin_d[i] = 1'($urandom_range(0, 1));
      sub_d[i] = 1'($urandom_range(0, 1));
      exp_d[i] = model(wid[i], sat[i], a_d[i], b_d[i], cin_d[i], sub_d[i]);
   endtask

   initial begin
      int issued;
      wid = '{24, 24, 8, 32, 24};
      stg = '{3, 3, 1, 4, 8};
      sat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < N; i++) begin
         iv_d[i] = 1'b0; cin_d[i] = 1'b0; sub_d[i] = 1'b0; ordy_d[i] = 1'b1;
         a_d[i] = '0; b_d[i] = '0; exp_d[i] = '0;
         wr_p[i] = 0; rd_p[i] = 0; stall_prev[i] = 1'b0; held[i] = '0; acc[i] = 1'b0;
      end

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < N; i++)
         chk($sformatf("reset[%0d]", i), {ov_o[i], co_o[i], sa_o[i][62:0]}, 65'(0));
      rst_n = 1'b1;
      #1;
      for (int i = 0; i < N; i++)
         chk($sformatf("ready_after_reset[%0d]", i), 65'(ir_o[i]), 65'(1));
      @(negedge clk);

      // Directed back-to-back adds/subtracts on the two default-width pipelines.
      chk_lat = 1'b1;
      for (int j = 0; j < 10; j++) begin
         for (int i = 0; i < 2; i++) begin
            iv_d[i]  = 1'b1;
            a_d[i]   = 64'(d_a[j]);
            b_d[i]   = 64'(d_b[j]);
            cin_d[i] = d_cin[j];
            sub_d[i] = d_sub[j];
         end
         exp_d[0] = {d_e0[j][24], 40'd0, d_e0[j][23:0]};
         exp_d[1] = {d_e1[j][24], 40'd0, d_e1[j][23:0]};
         cycle();
      end
      drain(40);

      // Six operations with a four-cycle consumer stall in the middle.
      chk_lat = 1'b0;
      issued = 0;
      rand_op(0);
      a_d[1] = a_d[0]; b_d[1] = b_d[0]; cin_d[1] = cin_d[0]; sub_d[1] = sub_d[0];
      exp_d[1] = model(24, 1'b1, a_d[1], b_d[1], cin_d[1], sub_d[1]);
      for (int t = 0; t < 40 && (issued < 6 || t < 8); t++) begin
         for (int i = 0; i < 2; i++) begin
            ordy_d[i] = !(t >= 3 && t < 7);
            iv_d[i]   = (issued < 6);
         end
         cycle();
         if (acc[0]) begin
            issued++;
            rand_op(0);
            a_d[1] = a_d[0]; b_d[1] = b_d[0]; cin_d[1] = cin_d[0]; sub_d[1] = sub_d[0];
            exp_d[1] = model(24, 1'b1, a_d[1], b_d[1], cin_d[1], sub_d[1]);
         end
      end
      chk("bp_issued", 65'(issued), 65'(6));
      drain(40);

      // Asynchronous reset with two operations in flight.
      chk_lat = 1'b1;
      for (int j = 0; j < 2; j++) begin
         iv_d[0] = 1'b1;
         rand_op(0);
         cycle();
      end
      iv_d[0] = 1'b0;
      cycle();
      #1;
      chk("pre_reset_valid", 65'(ov_o[0]), 65'(1));
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         chk($sformatf("async_reset[%0d]", i), {ov_o[i], co_o[i], sa_o[i][62:0]}, 65'(0));
         rd_p[i] = wr_p[i];
         stall_prev[i] = 1'b0;
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      repeat (6) cycle();
      iv_d[0] = 1'b1;
      rand_op(0);
      cycle();
      drain(20);

      // Random traffic with random backpressure on every parameterisation.
      chk_lat = 1'b0;
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < N; i++) begin
            iv_d[i]   = ($urandom_range(0, 3) != 0);
            ordy_d[i] = ($urandom_range(0, 3) != 0);
            rand_op(i);
         end
         cycle();
      end
      drain(100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
